// File: rtl/jk_pkg.sv
// Shared types and JK excitation helper for the JK bank driver.
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_t;

    // {j, k} pairs understood by the synchronous-reset JK cell.
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;

    // Only the set/reset/hold encodings are ever produced; 11 is unreachable.
    function automatic logic [1:0] jk_excite(input logic want, input logic have);
        if (want && !have) begin
            return JK_SET;
        end
        if (!want && have) begin
            return JK_RST;
        end
        return JK_HOLD;
    endfunction

endpackage

// File: rtl/jk_excite_bit.sv
// Per-bit excitation cell: turns a wanted/observed bit pair into a J/K pair.
module jk_excite_bit
    import jk_pkg::*;
(
    input  logic want,
    input  logic have,
    output logic j,
    output logic k
);

    assign {j, k} = jk_excite(want, have);

endmodule

// File: rtl/jk_bank_driver.sv
// Drives a bank of JK flops toward a target word, verifies Q after settle,
// retries a bounded number of times and flags an error if the bank never matches.
module jk_bank_driver
    import jk_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SETTLE_CYC = 1,
    parameter int MAX_RETRY  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] q_obs,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             err_sticky
);

    localparam logic [3:0] SETTLE_LOAD = (SETTLE_CYC > 0) ? 4'(SETTLE_CYC - 1) : 4'd0;
    localparam logic [2:0] RETRY_MAX   = 3'(MAX_RETRY);

    state_t           state;
    logic [2:0]       retry;
    logic [3:0]       settle_cnt;
    logic [WIDTH-1:0] target;

    logic [WIDTH-1:0] want;
    logic [WIDTH-1:0] exc_j;
    logic [WIDTH-1:0] exc_k;

    // j/k are registered, so the excitation is computed on the edge that enters
    // DRIVE: from the incoming word on acceptance, from the latched word on retry.
    assign want = (state == IDLE) ? tgt_data : target;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_excite_bit u_bit (
            .want (want[i]),
            .have (q_obs[i]),
            .j    (exc_j[i]),
            .k    (exc_k[i])
        );
    end

    // NOTE: all state lives in this one block and is written with <= so every
    // register samples the pre-edge values of the others, regardless of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            retry      <= '0;
            settle_cnt <= '0;
            // NOTE: the target register is cleared as well so no stale word can
            // reach a compare after an aborted transaction.
            target     <= '0;
            j          <= '0;
            k          <= '0;
            tgt_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            j    <= '0;
            k    <= '0;

            case (state)
                IDLE: begin
                    if (tgt_valid && tgt_ready) begin
                        target    <= tgt_data;
                        retry     <= '0;
                        j         <= exc_j;
                        k         <= exc_k;
                        tgt_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= DRIVE;
                    end
                end

                DRIVE: begin
                    if (SETTLE_CYC > 0) begin
                        settle_cnt <= SETTLE_LOAD;
                        state      <= SETTLE;
                    end else begin
                        state <= CHECK;
                    end
                end

                SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end

                CHECK: begin
                    if (q_obs == target) begin
                        done      <= 1'b1;
                        tgt_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (retry < RETRY_MAX) begin
                        retry <= retry + 3'd1;
                        j     <= exc_j;
                        k     <= exc_k;
                        state <= DRIVE;
                    end else begin
                        err        <= 1'b1;
                        err_sticky <= 1'b1;
                        tgt_ready  <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: begin
                    tgt_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // The JK cell's 11 pair toggles on some variants; it must never be driven.
    assert property (@(posedge clk) disable iff (rst) (j & k) == '0);

endmodule

// File: tb/tb_jk_bank_driver.sv
// Directed bench for jk_bank_driver with a behavioural JK bank and a stuck-bit fault hook.
module tb_jk_bank_driver;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             tgt_valid;
    logic [WIDTH-1:0] tgt_data;
    logic             tgt_ready;
    logic [WIDTH-1:0] q_obs;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             busy;
    logic             done;
    logic             err;
    logic             err_sticky;

    logic             bank_clr;
    logic [WIDTH-1:0] bank_q;
    logic [WIDTH-1:0] stuck;

    int vectors     = 0;
    int miscompares = 0;

    jk_bank_driver #(
        .WIDTH      (WIDTH),
        .SETTLE_CYC (1),
        .MAX_RETRY  (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tgt_valid  (tgt_valid),
        .tgt_data   (tgt_data),
        .tgt_ready  (tgt_ready),
        .q_obs      (q_obs),
        .j          (j),
        .k          (k),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    // Behavioural JK bank; bits in 'stuck' read back as 0 whatever the flop holds.
    always_ff @(posedge clk) begin
        if (bank_clr) begin
            bank_q <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                case ({j[i], k[i]})
                    2'b10:   bank_q[i] <= 1'b1;
                    2'b01:   bank_q[i] <= 1'b0;
                    default: bank_q[i] <= bank_q[i];
                endcase
            end
        end
    end

    assign q_obs = bank_q & ~stuck;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clean transaction at SETTLE_CYC=1: accept, DRIVE, SETTLE, CHECK, done.
    task automatic run_txn(input logic [WIDTH-1:0] data,
                           input logic [WIDTH-1:0] exp_j,
                           input logic [WIDTH-1:0] exp_k);
        tgt_valid = 1'b1;
        tgt_data  = data;
        step();
        tgt_valid = 1'b0;
        tgt_data  = ~data;
        check("drive_busy", busy, 1);
        check("drive_ready", tgt_ready, 0);
        check("drive_j", j, exp_j);
        check("drive_k", k, exp_k);
        check("drive_jk_excl", j & k, 0);
        step();
        check("settle_jk", {j, k}, 0);
        check("settle_done", done, 0);
        step();
        check("check_done", done, 0);
        step();
        check("done_pulse", done, 1);
        check("done_err", err, 0);
        check("done_ready", tgt_ready, 1);
        check("done_busy", busy, 0);
        check("bank_value", q_obs, data);
        step();
        check("done_clear", done, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_drive;
        int got_err;
        int got_done;

        rst       = 1'b1;
        bank_clr  = 1'b1;
        stuck     = '0;
        tgt_valid = 1'b1;
        tgt_data  = 8'hFF;
        step();
        step();
        check("rst_ready", tgt_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_jk", {j, k}, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_sticky", err_sticky, 0);

        rst       = 1'b0;
        bank_clr  = 1'b0;
        tgt_valid = 1'b0;
        step();
        check("post_rst_ready", tgt_ready, 1);
        check("post_rst_busy", busy, 0);
        check("post_rst_jk", {j, k}, 0);

        run_txn(8'hA5, 8'hA5, 8'h00);
        run_txn(8'h5A, 8'h5A, 8'hA5);

        // Bit 0 reads back as 0: one drive plus three retries, then err.
        stuck     = 8'h01;
        tgt_valid = 1'b1;
        tgt_data  = 8'h01;
        step();
        tgt_valid = 1'b0;
        check("stuck_first_k", k, 8'h5A);
        n_drive  = 0;
        got_err  = 0;
        got_done = 0;
        for (int c = 0; c < 40 && got_err == 0; c++) begin
            if (j != '0) begin
                n_drive++;
                check("stuck_j", j, 8'h01);
            end
            if (done) got_done = 1;
            if (err) got_err = 1;
            else step();
        end
        check("stuck_err_seen", got_err, 1);
        check("stuck_drive_count", n_drive, 4);
        check("stuck_no_done", got_done, 0);
        check("stuck_sticky", err_sticky, 1);
        check("stuck_ready", tgt_ready, 1);
        check("stuck_busy", busy, 0);
        step();
        check("stuck_err_pulse", err, 0);
        check("stuck_sticky_hold", err_sticky, 1);

        stuck = '0;
        run_txn(8'h3C, 8'h3C, 8'h01);
        run_txn(8'h3C, 8'h00, 8'h00);
        check("sticky_survives", err_sticky, 1);

        // Valid held high across three targets; reset lands in SETTLE of the second.
        tgt_valid = 1'b1;
        tgt_data  = 8'hC3;
        step();
        check("b2b1_j", j, 8'hC3);
        check("b2b1_k", k, 8'h3C);
        tgt_data = 8'h0F;
        step();
        check("b2b1_stall_ready", tgt_ready, 0);
        check("b2b1_stall_jk", {j, k}, 0);
        step();
        check("b2b1_check_jk", {j, k}, 0);
        step();
        check("b2b1_done", done, 1);
        check("b2b1_bank", q_obs, 8'hC3);
        check("b2b1_ready", tgt_ready, 1);
        step();
        check("b2b2_accept_busy", busy, 1);
        check("b2b2_j", j, 8'h0C);
        check("b2b2_k", k, 8'hC0);
        tgt_data = 8'hF0;
        step();
        check("b2b2_settle_jk", {j, k}, 0);
        rst = 1'b1;
        step();
        check("abort_busy", busy, 0);
        check("abort_ready", tgt_ready, 1);
        check("abort_done", done, 0);
        check("abort_sticky", err_sticky, 0);
        check("abort_jk", {j, k}, 0);
        rst = 1'b0;
        step();
        check("b2b3_no_done", done, 0);
        check("b2b3_j", j, 8'hF0);
        check("b2b3_k", k, 8'h0F);
        tgt_valid = 1'b0;
        step();
        check("b2b3_settle_done", done, 0);
        step();
        check("b2b3_check_done", done, 0);
        step();
        check("b2b3_done", done, 1);
        check("b2b3_err", err, 0);
        check("b2b3_bank", q_obs, 8'hF0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
